// File: rtl/johnson_code_checker_if.sv
// Handshake bundle for johnson_code_checker: code samples in, status out.
// master drives code_valid/code_in/err_clr; slave returns decode and status.
interface johnson_code_checker_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  localparam int IW = $clog2(2*WIDTH);

  logic                 code_valid;
  logic [WIDTH-1:0]     code_in;
  logic                 err_clr;
  logic                 idx_valid;
  logic [IW-1:0]        idx_out;
  logic                 locked;
  logic                 illegal_err;
  logic                 seq_err;
  logic                 wrap_pulse;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output code_valid, code_in, err_clr,
    input  idx_valid, idx_out, locked,
    input  illegal_err, seq_err, wrap_pulse, err_count
  );

  modport slave (
    input  code_valid, code_in, err_clr,
    output idx_valid, idx_out, locked,
    output illegal_err, seq_err, wrap_pulse, err_count
  );
endinterface

// File: rtl/johnson_code_checker.sv
// Johnson code decoder + sequence monitor: legality, index, lock, wrap, errors.
// Ports: clk, rst (sync, active high), bus (slave: code in, status out).
module johnson_code_checker #(
  parameter int WIDTH       = 4,
  parameter int LOCK_THRESH = 2,
  parameter int ERR_CNT_W   = 8
) (
  input logic                   clk,
  input logic                   rst,
  johnson_code_checker_if.slave bus
);
  localparam int IW = $clog2(2*WIDTH);
  localparam int HW = $clog2(LOCK_THRESH+1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t               state;
  logic [WIDTH-1:0]     last_code;
  logic                 have_code;
  logic [HW-1:0]        hunt_cnt;
  logic                 idx_valid;
  logic [IW-1:0]        idx_out;
  logic                 locked;
  logic                 illegal_err;
  logic                 seq_err;
  logic                 wrap_pulse;
  logic [ERR_CNT_W-1:0] err_count;

  logic [WIDTH-1:0] code;
  logic [WIDTH-1:0] succ;
  logic             legal;
  logic             is_succ;
  logic [IW-1:0]    idx;
  logic             err_ev;

  assign code = bus.code_in;
  assign succ = {last_code[WIDTH-2:0], ~last_code[WIDTH-1]};
  assign is_succ = have_code && (code == succ);

  always_comb begin
    int trans;
    int ones;
    trans = 0;
    ones  = 0;
    for (int i = 0; i < WIDTH-1; i++)
      trans += int'(code[i] ^ code[i+1]);
    for (int i = 0; i < WIDTH; i++)
      ones += int'(code[i]);
    legal = (trans <= 1);
    if (code[WIDTH-1])
      idx = IW'(2*WIDTH - ones);
    else
      idx = IW'(ones);
  end

  // One error per sample: illegal anywhere, or an off-sequence code
  // while locked.
  assign err_ev = bus.code_valid &&
                  (!legal || (state == LOCKED && !is_succ));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      last_code   <= '0;
      have_code   <= 1'b0;
      hunt_cnt    <= '0;
      idx_valid   <= 1'b0;
      idx_out     <= '0;
      locked      <= 1'b0;
      illegal_err <= 1'b0;
      seq_err     <= 1'b0;
      wrap_pulse  <= 1'b0;
      err_count   <= '0;
    end else begin
      idx_valid   <= 1'b0;
      illegal_err <= 1'b0;
      seq_err     <= 1'b0;
      wrap_pulse  <= 1'b0;

      if (bus.err_clr)
        err_count <= err_ev ? ERR_CNT_W'(1) : '0;
      else if (err_ev && err_count != '1)
        err_count <= err_count + ERR_CNT_W'(1);

      if (bus.code_valid) begin
        if (!legal) begin
          illegal_err <= 1'b1;
          hunt_cnt    <= '0;
          state       <= HUNT;
          locked      <= 1'b0;
        end else begin
          idx_valid <= 1'b1;
          idx_out   <= idx;
          last_code <= code;
          have_code <= 1'b1;
          unique case (1'b1)
            state == LOCKED && is_succ: begin
              // Only 10..0 advances to all-zeros: index 2W-1 -> 0.
              wrap_pulse <= (code == '0);
            end
            state == LOCKED && !is_succ: begin
              seq_err  <= 1'b1;
              state    <= HUNT;
              locked   <= 1'b0;
              hunt_cnt <= '0;
            end
            state == HUNT && is_succ: begin
              hunt_cnt <= hunt_cnt + HW'(1);
              if (hunt_cnt == HW'(LOCK_THRESH-1)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
            default: hunt_cnt <= '0;
          endcase
        end
      end
    end
  end

  assign bus.idx_valid   = idx_valid;
  assign bus.idx_out     = idx_out;
  assign bus.locked      = locked;
  assign bus.illegal_err = illegal_err;
  assign bus.seq_err     = seq_err;
  assign bus.wrap_pulse  = wrap_pulse;
  assign bus.err_count   = err_count;
endmodule

// File: tb/tb_johnson_code_checker.sv
// Scoreboard bench for johnson_code_checker (WIDTH=4, LOCK_THRESH=2).
// Two DUTs share stimulus: ERR_CNT_W=8 (full check) and 2 (saturation).
module tb_johnson_code_checker;
  localparam int W  = 4;
  localparam int N  = 2*W;
  localparam int LT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  johnson_code_checker_if #(.WIDTH(W), .ERR_CNT_W(8)) bus_a ();
  johnson_code_checker_if #(.WIDTH(W), .ERR_CNT_W(2)) bus_b ();

  johnson_code_checker #(.WIDTH(W), .LOCK_THRESH(LT), .ERR_CNT_W(8))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  johnson_code_checker #(.WIDTH(W), .LOCK_THRESH(LT), .ERR_CNT_W(2))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  typedef struct {
    int idx_valid;
    int idx_out;
    int locked;
    int illegal;
    int seq;
    int wrap;
    int ec8;
    int ec2;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference: the legal codes in counting order, built by walking the
  // Johnson successor rule from all-zeros.
  int seq_tab[N];
  int m_locked, m_hunt, m_have, m_last, m_idx, m_ec8, m_ec2;

  function automatic int find_idx(input int c);
    for (int k = 0; k < N; k++)
      if (seq_tab[k] == c) return k;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d @%0t", name, act, exp,
               $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input int c,
                      input bit clr);
    exp_t e;
    int   k;
    bit   s;
    bit   err;
    @(negedge clk);
    rst = r;
    bus_a.code_valid = v;  bus_b.code_valid = v;
    bus_a.code_in = 4'(c); bus_b.code_in = 4'(c);
    bus_a.err_clr = clr;   bus_b.err_clr = clr;
    e = '{default: 0};
    if (r) begin
      m_locked = 0; m_hunt = 0; m_have = 0; m_last = 0;
      m_idx = 0; m_ec8 = 0; m_ec2 = 0;
    end else begin
      err = 0;
      if (v) begin
        k = find_idx(c);
        if (k < 0) begin
          e.illegal = 1; err = 1; m_locked = 0; m_hunt = 0;
        end else begin
          s = m_have != 0 && k == (m_last + 1) % N;
          e.idx_valid = 1;
          m_idx = k;
          if (m_locked != 0) begin
            if (s) e.wrap = (k == 0);
            else begin
              e.seq = 1; err = 1; m_locked = 0; m_hunt = 0;
            end
          end else if (s) begin
            m_hunt++;
            if (m_hunt >= LT) m_locked = 1;
          end else m_hunt = 0;
          m_last = k; m_have = 1;
        end
      end
      if (clr) begin
        m_ec8 = err; m_ec2 = err;
      end else if (err) begin
        if (m_ec8 < 255) m_ec8++;
        if (m_ec2 < 3) m_ec2++;
      end
    end
    e.idx_out = m_idx;
    e.locked  = m_locked;
    e.ec8     = m_ec8;
    e.ec2     = m_ec2;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs update every edge, so one expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("idx_valid", 32'(bus_a.idx_valid), e.idx_valid);
        chk("idx_out", 32'(bus_a.idx_out), e.idx_out);
        chk("locked", 32'(bus_a.locked), e.locked);
        chk("illegal_err", 32'(bus_a.illegal_err), e.illegal);
        chk("seq_err", 32'(bus_a.seq_err), e.seq);
        chk("wrap_pulse", 32'(bus_a.wrap_pulse), e.wrap);
        chk("err_count8", 32'(bus_a.err_count), e.ec8);
        chk("err_count2", 32'(bus_b.err_count), e.ec2);
      end
    end
  end

  int c;
  int p;
  bit r, v, clr;

  initial begin
    seq_tab[0] = 0;
    for (int k = 1; k < N; k++)
      seq_tab[k] = ((seq_tab[k-1] << 1) |
                    (((seq_tab[k-1] >> (W-1)) & 1) ^ 1)) & (N*2-1);
    bus_a.code_valid = 0; bus_b.code_valid = 0;
    bus_a.code_in = '0;   bus_b.code_in = '0;
    bus_a.err_clr = 0;    bus_b.err_clr = 0;

    // acquire and full cycle with wrap
    step(1, 1, 'b0101, 0);
    step(0, 1, 'b0000, 0);
    step(0, 1, 'b0001, 0);
    step(0, 1, 'b0011, 0);
    step(0, 1, 'b0111, 0);
    step(0, 1, 'b1111, 0);
    step(0, 1, 'b1110, 0);
    step(0, 1, 'b1100, 0);
    step(0, 1, 'b1000, 0);
    step(0, 1, 'b0000, 0);
    step(0, 1, 'b0001, 0);
    step(0, 1, 'b0011, 0);
    // illegal while locked, then relock
    step(0, 1, 'b0101, 0);
    step(0, 1, 'b0111, 0);
    step(0, 1, 'b1111, 0);
    // sequence skip while locked, then relock
    step(0, 1, 'b0000, 0);
    step(0, 1, 'b0001, 0);
    step(0, 1, 'b0011, 0);
    // gaps
    step(0, 0, 'b1010, 0);
    step(0, 0, 'b0111, 0);
    step(0, 0, 'b0000, 0);
    step(0, 1, 'b0111, 0);
    step(0, 1, 'b0010, 0);
    // mid-stream reset with errors pending, valid code present
    step(1, 1, 'b1111, 0);
    step(0, 1, 'b1011, 0);
    step(0, 1, 'b1101, 1);
    step(0, 0, 'b0000, 1);
    // saturate the 2-bit counter
    for (int i = 0; i < 5; i++) step(0, 1, 'b0100, 0);
    step(0, 1, 'b0110, 1);

    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 299) == 0);
      v   = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 39) == 0);
      p   = $urandom_range(0, 99);
      if (p < 78) c = seq_tab[(m_last + 1) % N];
      else if (p < 88) c = seq_tab[$urandom_range(0, N-1)];
      else begin
        c = $urandom_range(0, 15);
        while (find_idx(c) >= 0) c = $urandom_range(0, 15);
      end
      step(r, v, c, clr);
    end

    step(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
